// File: rtl/dma_region_guard.sv
`default_nettype none
// ============================================================================
// Module   : dma_region_guard
// Brief    : Multi-region DMA guard. Each region either forbids DMA while the
//            CPU executes inside it (mode 0, compares pc) or forbids DMA that
//            targets it (mode 1, compares dma_addr). A violation raises the
//            CPU reset request at once and holds it until the CPU has been
//            held for HOLD_CYCLES clean cycles and fetches from the reset
//            handler. Sticky per-region flags and a saturating counter record
//            violations for post-reboot software.
//            Optional macro DMA_GUARD_ADDR_LOG_EN builds first-violation
//            capture registers for dma_addr and pc.
// Revision : 1.0 - initial release
// ============================================================================
module dma_region_guard #(
    parameter int                    NUM_REG       = 2,
    parameter logic [16*NUM_REG-1:0] REG_BASE      = {16'hE000, 16'hA000},
    parameter logic [16*NUM_REG-1:0] REG_LAST      = {16'hEFFE, 16'hA0FE},
    parameter logic [NUM_REG-1:0]    REG_MODE      = 2'b10,
    parameter logic [15:0]           RESET_HANDLER = 16'h0000,
    parameter int                    HOLD_CYCLES   = 4,
    parameter int                    CNT_W         = 8
) (
    input  logic               clk,
    input  logic               puc_rst,
    input  logic [15:0]        pc,
    input  logic [15:0]        dma_addr,
    input  logic               dma_en,
    output logic               reset,
    output logic [NUM_REG-1:0] viol_region,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic [15:0]        viol_addr,
    output logic [15:0]        viol_pc
);

    localparam logic [7:0] C_HOLD = 8'(HOLD_CYCLES);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_t;

    state_t             r_state;
    logic [7:0]         r_hold;
    logic [NUM_REG-1:0] w_hit;
    logic               w_invalid;
    logic               w_enter_kill;

    // Per-region window compare; each region is independent so overlaps are fine
    for (genvar i = 0; i < NUM_REG; i++) begin : g_region
        logic [15:0] w_cmp;
        assign w_cmp    = REG_MODE[i] ? dma_addr : pc;
        assign w_hit[i] = dma_en
                          && (w_cmp >= REG_BASE[16*i +: 16])
                          && (w_cmp <= REG_LAST[16*i +: 16]);
    end

    assign w_invalid    = |w_hit;
    assign w_enter_kill = (r_state == ST_RUN) && w_invalid;

    // Combinational so a violation in RUN cuts the CPU off in the same cycle
    assign reset = (r_state == ST_KILL) || w_invalid;

    // RUN/KILL state machine with the clean-cycle hold countdown
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state <= ST_KILL;
            r_hold  <= C_HOLD;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_invalid) begin
                        r_state <= ST_KILL;
                        r_hold  <= C_HOLD;
                    end
                end
                ST_KILL: begin
                    // Any violation restarts the countdown and blocks release
                    if (w_invalid) begin
                        r_hold <= C_HOLD;
                    end else if (r_hold != 8'd0) begin
                        r_hold <= r_hold - 8'd1;
                    end else if (pc == RESET_HANDLER) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_KILL;
                    r_hold  <= C_HOLD;
                end
            endcase
        end
    end

    // Sticky region flags (set only while running) and saturating violation count
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            viol_region <= '0;
            viol_cnt    <= '0;
        end else begin
            if (r_state == ST_RUN) begin
                viol_region <= viol_region | w_hit;
            end
            if (w_enter_kill && (viol_cnt != '1)) begin
                viol_cnt <= viol_cnt + 1'b1;
            end
        end
    end

`ifdef DMA_GUARD_ADDR_LOG_EN
    logic r_log_valid;

    // Capture the bus state of the first violation since the last puc_rst only
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            r_log_valid <= 1'b0;
            viol_addr   <= 16'h0000;
            viol_pc     <= 16'h0000;
        end else if (w_enter_kill && !r_log_valid) begin
            r_log_valid <= 1'b1;
            viol_addr   <= dma_addr;
            viol_pc     <= pc;
        end
    end
`else
    assign viol_addr = 16'h0000;
    assign viol_pc   = 16'h0000;
`endif

endmodule
`default_nettype wire
